// File: rtl/warp_ibuffer_if.sv
// Handshake bundle for warp_ibuffer: one enqueue port, per-warp dequeue ports, flush and occupancy.
// master = producer/consumer side, slave = the buffer itself.
interface warp_ibuffer_if #(
  parameter int NUM_WARPS  = 8,
  parameter int DEPTH      = 4,
  parameter int ENTRY_BITS = 64
);
  localparam int WID_BITS = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int CNT_BITS = $clog2(DEPTH + 1);

  logic                           enq_valid;
  logic                           enq_ready;
  logic [WID_BITS-1:0]            enq_wid;
  logic [ENTRY_BITS-1:0]          enq_data;
  logic [NUM_WARPS-1:0]           deq_ready;
  logic [NUM_WARPS-1:0]           deq_valid;
  logic [NUM_WARPS*ENTRY_BITS-1:0] deq_data;
  logic                           flush_valid;
  logic [WID_BITS-1:0]            flush_wid;
  logic [NUM_WARPS*CNT_BITS-1:0]  count;
  logic                           all_empty;

  modport master (
    output enq_valid, enq_wid, enq_data, deq_ready, flush_valid, flush_wid,
    input  enq_ready, deq_valid, deq_data, count, all_empty
  );

  modport slave (
    input  enq_valid, enq_wid, enq_data, deq_ready, flush_valid, flush_wid,
    output enq_ready, deq_valid, deq_data, count, all_empty
  );
endinterface

// File: rtl/warp_ibuffer.sv
// Per-warp instruction buffer: NUM_WARPS circular FIFOs, enq->deq latency 1 cycle (0 for an empty warp with WARP_IBUFFER_BYPASS_EN).
// Backpressure: enq_ready drops for a full, same-cycle-flushed or out-of-range warp; each warp dequeues on its own deq_ready.
module warp_ibuffer #(
  parameter int NUM_WARPS  = 8,
  parameter int DEPTH      = 4,
  parameter int ENTRY_BITS = 64
) (
  input  logic           clock,
  input  logic           reset,
  warp_ibuffer_if.slave  bus
);
  localparam int WID_BITS = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int CNT_BITS = $clog2(DEPTH + 1);
  localparam int PTR_BITS = $clog2(DEPTH);

  logic [PTR_BITS-1:0]   head_q [NUM_WARPS];
  logic [PTR_BITS-1:0]   head_d [NUM_WARPS];
  logic [PTR_BITS-1:0]   tail_q [NUM_WARPS];
  logic [PTR_BITS-1:0]   tail_d [NUM_WARPS];
  logic [CNT_BITS-1:0]   cnt_q  [NUM_WARPS];
  logic [CNT_BITS-1:0]   cnt_d  [NUM_WARPS];
  logic [ENTRY_BITS-1:0] mem_q  [NUM_WARPS][DEPTH];

  logic                  wid_ok;
  logic                  tgt_full;
  logic                  enq_rdy;
  logic                  enq_fire;
  logic [NUM_WARPS-1:0]  enq_sel;
  logic [NUM_WARPS-1:0]  wr_sel;
  logic [NUM_WARPS-1:0]  pop;
  logic [NUM_WARPS-1:0]  flush_sel;
  logic [NUM_WARPS-1:0]  byp;
  logic [NUM_WARPS-1:0]  deq_vld;
  logic [NUM_WARPS*ENTRY_BITS-1:0] deq_dat;
  logic [NUM_WARPS*CNT_BITS-1:0]   cnt_flat;
  logic                  empty_all;

  // Ready depends only on registered counts and the enqueue/flush request, never on deq_ready.
  always_comb begin
    wid_ok   = 32'(bus.enq_wid) < NUM_WARPS;
    tgt_full = 1'b0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (bus.enq_wid == WID_BITS'(w)) tgt_full = (cnt_q[w] == CNT_BITS'(DEPTH));
    end
    enq_rdy  = wid_ok && !tgt_full && !(bus.flush_valid && (bus.flush_wid == bus.enq_wid));
    enq_fire = bus.enq_valid && enq_rdy;
  end

  always_comb begin
    empty_all = 1'b1;
    cnt_flat  = '0;
    deq_dat   = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      enq_sel[w]   = enq_fire && (bus.enq_wid == WID_BITS'(w));
      flush_sel[w] = bus.flush_valid && (bus.flush_wid == WID_BITS'(w));
`ifdef WARP_IBUFFER_BYPASS_EN
      byp[w]       = enq_sel[w] && (cnt_q[w] == '0) && !flush_sel[w];
`else
      byp[w]       = 1'b0;
`endif
      deq_vld[w]   = (cnt_q[w] != '0) || byp[w];
      pop[w]       = (cnt_q[w] != '0) && bus.deq_ready[w];
      // A bypassed entry taken by the consumer this cycle never lands in storage.
      wr_sel[w]    = enq_sel[w] && !(byp[w] && bus.deq_ready[w]);
      deq_dat[ENTRY_BITS*w +: ENTRY_BITS] = byp[w] ? bus.enq_data : mem_q[w][head_q[w]];

      head_d[w] = head_q[w] + PTR_BITS'(pop[w]);
      tail_d[w] = tail_q[w] + PTR_BITS'(wr_sel[w]);
      cnt_d[w]  = cnt_q[w] + CNT_BITS'(wr_sel[w]) - CNT_BITS'(pop[w]);
      if (flush_sel[w]) begin
        head_d[w] = '0;
        tail_d[w] = '0;
        cnt_d[w]  = '0;
      end

      cnt_flat[CNT_BITS*w +: CNT_BITS] = cnt_q[w];
      if (cnt_q[w] != '0) empty_all = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        head_q[w] <= '0;
        tail_q[w] <= '0;
        cnt_q[w]  <= '0;
      end
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        head_q[w] <= head_d[w];
        tail_q[w] <= tail_d[w];
        cnt_q[w]  <= cnt_d[w];
      end
    end
  end

  // Payload storage is not reset; validity is carried entirely by the counts.
  always_ff @(posedge clock) begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (wr_sel[w]) mem_q[w][tail_q[w]] <= bus.enq_data;
    end
  end

  assign bus.enq_ready = enq_rdy;
  assign bus.deq_valid = deq_vld;
  assign bus.deq_data  = deq_dat;
  assign bus.count     = cnt_flat;
  assign bus.all_empty = empty_all;

endmodule

// File: tb/tb_warp_ibuffer.sv
// Bench for warp_ibuffer: directed scenarios plus random traffic checked against per-warp queue model.
// A second 6-warp instance exercises out-of-range warp ids.
module tb_warp_ibuffer;
  localparam int NW = 8;
  localparam int D  = 4;
  localparam int EB = 64;
  localparam int WB = 3;
  localparam int CB = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  warp_ibuffer_if #(.NUM_WARPS(NW), .DEPTH(D), .ENTRY_BITS(EB)) bus ();
  warp_ibuffer_if #(.NUM_WARPS(6),  .DEPTH(D), .ENTRY_BITS(EB)) bus6 ();

  warp_ibuffer #(.NUM_WARPS(NW), .DEPTH(D), .ENTRY_BITS(EB)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  warp_ibuffer #(.NUM_WARPS(6), .DEPTH(D), .ENTRY_BITS(EB)) dut6 (
    .clock (clock),
    .reset (reset),
    .bus   (bus6)
  );

  int checks   = 0;
  int failures = 0;
  logic [EB-1:0] mq [NW][$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [63:0] cnt_of(input int w);
    logic [NW*CB-1:0] c;
    c = bus.count;
    return 64'(c[CB*w +: CB]);
  endfunction

  function automatic logic [63:0] dat_of(input int w);
    logic [NW*EB-1:0] d;
    d = bus.deq_data;
    return d[EB*w +: EB];
  endfunction

  // Called just after a rising edge; drives one cycle, checks before the next edge, advances the model.
  task automatic cyc(input logic ev, input int wid, input logic [EB-1:0] dat,
                     input logic [NW-1:0] dr, input logic fv, input int fw);
    logic exp_rdy;
    logic all_e;
    logic byp_w;
    int   pre [NW];
    bus.enq_valid   = ev;
    bus.enq_wid     = WB'(wid);
    bus.enq_data    = dat;
    bus.deq_ready   = dr;
    bus.flush_valid = fv;
    bus.flush_wid   = WB'(fw);
    @(negedge clock);
    exp_rdy = (wid < NW) && (mq[wid].size() != D) && !(fv && fw == wid);
    chk("enq_ready", 64'(bus.enq_ready), 64'(exp_rdy));
    all_e = 1'b1;
    byp_w = 1'b0;
    for (int w = 0; w < NW; w++) begin
      logic byp;
      pre[w] = mq[w].size();
      byp = 1'b0;
`ifdef WARP_IBUFFER_BYPASS_EN
      byp = ev && exp_rdy && (wid == w) && (pre[w] == 0);
`endif
      if (w == wid) byp_w = byp;
      chk($sformatf("deq_valid[%0d]", w), 64'(bus.deq_valid[w]), 64'((pre[w] != 0) || byp));
      chk($sformatf("count[%0d]", w), cnt_of(w), 64'(pre[w]));
      if (pre[w] != 0) chk($sformatf("deq_data[%0d]", w), dat_of(w), mq[w][0]);
      else if (byp) chk($sformatf("byp_data[%0d]", w), dat_of(w), dat);
      if (pre[w] != 0) all_e = 1'b0;
    end
    chk("all_empty", 64'(bus.all_empty), 64'(all_e));
    for (int w = 0; w < NW; w++) begin
      if (fv && fw == w) mq[w].delete();
      else if (pre[w] != 0 && dr[w]) void'(mq[w].pop_front());
    end
    if (ev && exp_rdy && !(byp_w && dr[wid])) mq[wid].push_back(dat);
    @(posedge clock);
    #1;
  endtask

  logic [EB-1:0] ord [4];

  initial begin
    bus.enq_valid = 0; bus.enq_wid = '0; bus.enq_data = '0;
    bus.deq_ready = '0; bus.flush_valid = 0; bus.flush_wid = '0;
    bus6.enq_valid = 0; bus6.enq_wid = '0; bus6.enq_data = '0;
    bus6.deq_ready = '0; bus6.flush_valid = 0; bus6.flush_wid = '0;
    ord[0] = 64'h11; ord[1] = 64'h22; ord[2] = 64'h33; ord[3] = 64'h44;

    #1;
    chk("rst_all_empty", 64'(bus.all_empty), 64'd1);
    chk("rst_deq_valid", 64'(bus.deq_valid), 64'd0);
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_enq_ready", 64'(bus.enq_ready), 64'd1);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Fill warp 3, then verify full/other-warp readiness and rejection.
    for (int i = 0; i < 4; i++) cyc(1, 3, ord[i], '0, 0, 0);
    chk("full_count3", cnt_of(3), 64'd4);
    cyc(1, 3, 64'h55, '0, 0, 0);
    cyc(0, 5, 64'h0, '0, 0, 0);
    chk("full_count3_after_reject", cnt_of(3), 64'd4);

    // Drain warp 3 in order.
    for (int i = 0; i < 4; i++) begin
      chk("drain_order3", dat_of(3), ord[i]);
      cyc(0, 0, 64'h0, 8'h08, 0, 0);
    end
    chk("drain_count3", cnt_of(3), 64'd0);
    chk("drain_all_empty", 64'(bus.all_empty), 64'd1);

    // Warp 2 at count 2, simultaneous enq+deq wraps the pointers.
    cyc(1, 2, 64'hA0, '0, 0, 0);
    cyc(1, 2, 64'hA1, '0, 0, 0);
    for (int i = 0; i < 7; i++) cyc(1, 2, 64'hB0 + 64'(i), 8'h04, 0, 0);
    chk("wrap_count2", cnt_of(2), 64'd2);
    chk("wrap_head2", dat_of(2), 64'hB5);

    // Flush warp 6 against same-warp and other-warp enqueue.
    for (int i = 0; i < 3; i++) cyc(1, 6, 64'h60 + 64'(i), '0, 0, 0);
    cyc(1, 6, 64'h66, 8'h40, 1, 6);
    chk("flush_count6", cnt_of(6), 64'd0);
    cyc(1, 6, 64'h67, '0, 0, 0);
    cyc(1, 1, 64'h77, '0, 1, 6);
    chk("flush_count6_b", cnt_of(6), 64'd0);
    chk("flush_other_count1", cnt_of(1), 64'd1);

    // Enqueue to an empty warp with the consumer ready.
    cyc(1, 4, 64'h55, 8'h10, 0, 0);
`ifdef WARP_IBUFFER_BYPASS_EN
    chk("byp_count4", cnt_of(4), 64'd0);
`else
    chk("late_valid4", 64'(bus.deq_valid[4]), 64'd1);
    chk("late_data4", dat_of(4), 64'h55);
`endif
    cyc(0, 0, 64'h0, '0, 0, 0);

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      logic [NW-1:0] dr;
      dr = NW'($urandom);
      if ($urandom_range(0, 3) == 0) dr = '0;
      cyc($urandom_range(0, 3) != 0, int'($urandom_range(0, NW - 1)),
          {$urandom, $urandom}, dr, $urandom_range(0, 9) == 0, int'($urandom_range(0, NW - 1)));
    end

    // Asynchronous reset between edges with warp 0 holding two entries.
    cyc(0, 0, 64'h0, '0, 1, 0);
    cyc(1, 0, 64'hC0, '0, 0, 0);
    cyc(1, 0, 64'hC1, '0, 0, 0);
    chk("pre_rst_count0", cnt_of(0), 64'd2);
    bus.enq_valid = 1; bus.enq_wid = '0; bus.deq_ready = '0; bus.flush_valid = 0;
    #3;
    reset = 1'b1;
    #1;
    chk("arst_count0", cnt_of(0), 64'd0);
    chk("arst_deq_valid", 64'(bus.deq_valid), 64'd0);
    chk("arst_all_empty", 64'(bus.all_empty), 64'd1);
    chk("arst_enq_ready", 64'(bus.enq_ready), 64'd1);
    @(posedge clock);
    #1;
    chk("arst_no_enq", 64'(bus.count), 64'd0);
    reset = 1'b0;
    for (int w = 0; w < NW; w++) mq[w].delete();
    for (int n = 0; n < 40; n++)
      cyc($urandom_range(0, 1) == 1, int'($urandom_range(0, NW - 1)), {$urandom, $urandom},
          NW'($urandom), 0, 0);

    // Out-of-range warp ids on a 6-warp buffer.
    bus6.enq_valid = 1;
    bus6.enq_wid = 3'd7;
    #1 chk("oor_rdy_wid7", 64'(bus6.enq_ready), 64'd0);
    bus6.enq_wid = 3'd6;
    #1 chk("oor_rdy_wid6", 64'(bus6.enq_ready), 64'd0);
    bus6.enq_wid = 3'd5;
    bus6.enq_data = 64'h5A;
    #1 chk("oor_rdy_wid5", 64'(bus6.enq_ready), 64'd1);
    @(posedge clock);
    #1;
    chk("oor_count_after_wid5", 64'(bus6.count), 64'h08000);
    bus6.enq_wid = 3'd6;
    bus6.flush_valid = 1;
    bus6.flush_wid = 3'd7;
    @(posedge clock);
    #1;
    chk("oor_count_unchanged", 64'(bus6.count), 64'h08000);
    chk("oor_not_empty", 64'(bus6.all_empty), 64'd0);
    bus6.enq_valid = 0;
    bus6.flush_valid = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
